// File: rtl/flit_injector.sv
// Upstream flit injector: segments descriptor + payload words into HEAD/BODY/TAIL/HEADTAIL
// flits and allocates a virtual channel round-robin, sending under per-VC on/off flow control.
//
// state | meaning
// IDLE  | waiting for a packet descriptor
// ALLOC | searching vc_allocatable_i round-robin from rr_ptr
// HEAD  | head flit pending until on_off_i[cur_vc]
// BODY  | streaming payload words, last one tagged TAIL
module flit_injector #(
   parameter int VC_NUM      = 2,
   parameter int FLIT_DATA_W = 32,
   parameter int DEST_W      = 4,
   parameter int LEN_W       = 4,
   localparam int VC_ID_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int FLIT_W     = 2 + VC_ID_W + FLIT_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pkt_valid_i,
   output logic                   pkt_ready_o,
   input  logic [DEST_W-1:0]      pkt_dest_x_i,
   input  logic [DEST_W-1:0]      pkt_dest_y_i,
   input  logic [LEN_W-1:0]       pkt_len_i,
   input  logic                   pld_valid_i,
   output logic                   pld_ready_o,
   input  logic [FLIT_DATA_W-1:0] pld_data_i,
   output logic [FLIT_W-1:0]      data_o,
   output logic                   valid_flit_o,
   input  logic [VC_NUM-1:0]      on_off_i,
   input  logic [VC_NUM-1:0]      vc_allocatable_i,
   output logic                   busy_o,
   output logic [15:0]            pkt_count_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALLOC = 2'd1,
      S_HEAD  = 2'd2,
      S_BODY  = 2'd3
   } state_t;

   localparam logic [1:0] FT_HEAD     = 2'b00;
   localparam logic [1:0] FT_BODY     = 2'b01;
   localparam logic [1:0] FT_TAIL     = 2'b10;
   localparam logic [1:0] FT_HEADTAIL = 2'b11;

   state_t                 state_q, state_d;
   logic [DEST_W-1:0]      dest_x_q, dest_x_d;
   logic [DEST_W-1:0]      dest_y_q, dest_y_d;
   logic [LEN_W-1:0]       rem_q, rem_d;
   logic [VC_ID_W-1:0]     cur_vc_q, cur_vc_d;
   logic [VC_ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [FLIT_W-1:0]      data_q, data_d;
   logic                   valid_q, valid_d;
   logic [15:0]            count_q, count_d;

   logic                   grant_found;
   logic [VC_ID_W-1:0]     grant_vc;
   logic [VC_ID_W-1:0]     grant_next;
   logic [VC_ID_W-1:0]     cand;
   logic [FLIT_DATA_W-1:0] head_pld;
   logic                   cur_on;

   // Round-robin search starting at rr_ptr; first allocatable VC wins.
   always_comb begin
      grant_found = 1'b0;
      grant_vc    = '0;
      cand        = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         cand = VC_ID_W'((int'(rr_ptr_q) + i) % VC_NUM);
         if (!grant_found && vc_allocatable_i[cand]) begin
            grant_found = 1'b1;
            grant_vc    = cand;
         end
      end
      grant_next = VC_ID_W'((int'(grant_vc) + 1) % VC_NUM);
   end

   always_comb begin
      head_pld                   = '0;
      head_pld[2*DEST_W-1:0]     = {dest_x_q, dest_y_q};
   end

   assign cur_on = on_off_i[cur_vc_q];

   always_comb begin
      state_d     = state_q;
      dest_x_d    = dest_x_q;
      dest_y_d    = dest_y_q;
      rem_d       = rem_q;
      cur_vc_d    = cur_vc_q;
      rr_ptr_d    = rr_ptr_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      count_d     = count_q;
      pkt_ready_o = 1'b0;
      pld_ready_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            pkt_ready_o = 1'b1;
            if (pkt_valid_i) begin
               dest_x_d = pkt_dest_x_i;
               dest_y_d = pkt_dest_y_i;
               rem_d    = pkt_len_i;
               state_d  = S_ALLOC;
            end
         end
         S_ALLOC: begin
            if (grant_found) begin
               cur_vc_d = grant_vc;
               rr_ptr_d = grant_next;
               state_d  = S_HEAD;
            end
         end
         S_HEAD: begin
            if (cur_on) begin
               valid_d = 1'b1;
               if (rem_q == '0) begin
                  data_d  = {FT_HEADTAIL, cur_vc_q, head_pld};
                  count_d = count_q + 16'd1;
                  state_d = S_IDLE;
               end else begin
                  data_d  = {FT_HEAD, cur_vc_q, head_pld};
                  state_d = S_BODY;
               end
            end
         end
         S_BODY: begin
            pld_ready_o = cur_on;
            if (cur_on && pld_valid_i) begin
               valid_d = 1'b1;
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  data_d  = {FT_TAIL, cur_vc_q, pld_data_i};
                  count_d = count_q + 16'd1;
                  state_d = S_IDLE;
               end else begin
                  data_d  = {FT_BODY, cur_vc_q, pld_data_i};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         dest_x_q <= '0;
         dest_y_q <= '0;
         rem_q    <= '0;
         cur_vc_q <= '0;
         rr_ptr_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         dest_x_q <= dest_x_d;
         dest_y_q <= dest_y_d;
         rem_q    <= rem_d;
         cur_vc_q <= cur_vc_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   assign data_o       = data_q;
   assign valid_flit_o = valid_q;
   assign busy_o       = (state_q != S_IDLE);
   assign pkt_count_o  = count_q;

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: flit content, latency, VC round-robin, backpressure,
// allocation stall, mid-packet reset and maximum-length packets.
module tb_flit_injector;

   localparam int VC_NUM      = 2;
   localparam int FLIT_DATA_W = 32;
   localparam int DEST_W      = 4;
   localparam int LEN_W       = 4;
   localparam int FLIT_W      = 2 + 1 + FLIT_DATA_W;

   logic                   clk;
   logic                   rst;
   logic                   pkt_valid_i;
   logic                   pkt_ready_o;
   logic [DEST_W-1:0]      pkt_dest_x_i;
   logic [DEST_W-1:0]      pkt_dest_y_i;
   logic [LEN_W-1:0]       pkt_len_i;
   logic                   pld_valid_i;
   logic                   pld_ready_o;
   logic [FLIT_DATA_W-1:0] pld_data_i;
   logic [FLIT_W-1:0]      data_o;
   logic                   valid_flit_o;
   logic [VC_NUM-1:0]      on_off_i;
   logic [VC_NUM-1:0]      vc_allocatable_i;
   logic                   busy_o;
   logic [15:0]            pkt_count_o;

   flit_injector #(
      .VC_NUM(VC_NUM), .FLIT_DATA_W(FLIT_DATA_W), .DEST_W(DEST_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst),
      .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
      .pkt_dest_x_i(pkt_dest_x_i), .pkt_dest_y_i(pkt_dest_y_i), .pkt_len_i(pkt_len_i),
      .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o), .pld_data_i(pld_data_i),
      .data_o(data_o), .valid_flit_o(valid_flit_o),
      .on_off_i(on_off_i), .vc_allocatable_i(vc_allocatable_i),
      .busy_o(busy_o), .pkt_count_o(pkt_count_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [FLIT_W-1:0]      fq[$];
   int                     fc[$];
   logic [FLIT_W-1:0]      exp_q[$];
   logic [FLIT_DATA_W-1:0] pld_q[$];
   logic                   pld_hs;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_flit_o) begin
         fq.push_back(data_o);
         fc.push_back(cyc);
      end
   end

   // Payload source: presents the head of pld_q, pops on an observed handshake.
   initial begin
      pld_valid_i = 1'b0;
      pld_data_i  = '0;
      forever begin
         @(negedge clk);
         pld_hs = pld_valid_i && pld_ready_o;
         @(posedge clk);
         #1;
         if (pld_hs && pld_q.size() > 0) void'(pld_q.pop_front());
         pld_valid_i = (pld_q.size() > 0);
         pld_data_i  = (pld_q.size() > 0) ? pld_q[0] : '0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: sim time exceeded, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic v,
                                            input logic [31:0] p);
      return {t, v, p};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_desc(input logic [3:0] dx, input logic [3:0] dy,
                            input logic [3:0] len, output int hs);
      logic got;
      got          = 1'b0;
      hs           = -1;
      pkt_valid_i  = 1'b1;
      pkt_dest_x_i = dx;
      pkt_dest_y_i = dy;
      pkt_len_i    = len;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = pkt_ready_o;
         @(posedge clk);
         #1;
         if (got) hs = cyc;
      end
      pkt_valid_i = 1'b0;
      check("desc_accept", {63'd0, got}, 64'd1);
   endtask

   task automatic wait_flits(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && fq.size() < n; i++) step();
      check({tag, "_count"}, fq.size(), n);
   endtask

   task automatic check_seq(input string tag, input bit chk_cyc, input int base);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < fq.size()) begin
            check($sformatf("%s_flit[%0d]", tag, i), fq[i], exp_q[i]);
            if (chk_cyc) check($sformatf("%s_cyc[%0d]", tag, i), fc[i], base + i);
         end
      end
   endtask

   int hs, h1, h2;

   initial begin
      rst              = 1'b0;
      pkt_valid_i      = 1'b0;
      pkt_dest_x_i     = '0;
      pkt_dest_y_i     = '0;
      pkt_len_i        = '0;
      on_off_i         = '0;
      vc_allocatable_i = '0;
      repeat (3) step();
      check("rst_valid", valid_flit_o, 0);
      check("rst_data", data_o, 0);
      check("rst_ready", pkt_ready_o, 1);
      check("rst_pld_ready", pld_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_count", pkt_count_o, 0);
      rst = 1'b1;
      repeat (3) step();
      check("idle_valid", valid_flit_o, 0);
      check("idle_ready", pkt_ready_o, 1);
      check("idle_busy", busy_o, 0);
      check("idle_count", pkt_count_o, 0);

      // Single-flit packet: HEADTAIL on vc 0, visible two edges after the handshake edge.
      vc_allocatable_i = 2'b11;
      on_off_i         = 2'b11;
      fq.delete(); fc.delete();
      send_desc(4'd2, 4'd3, 4'd0, hs);
      wait_flits("single", 1, 20);
      exp_q = '{mk(2'b11, 1'b0, 32'h23)};
      check_seq("single", 1'b1, hs + 2);
      check("single_pkt_count", pkt_count_o, 1);
      check("single_busy", busy_o, 0);

      // Four-word packet on vc 1 (rr_ptr advanced past 0), back-to-back flits.
      fq.delete(); fc.delete();
      for (int i = 0; i < 4; i++) pld_q.push_back(32'hA0 + i);
      send_desc(4'd5, 4'd1, 4'd4, hs);
      wait_flits("four", 5, 40);
      exp_q = '{mk(2'b00, 1'b1, 32'h51), mk(2'b01, 1'b1, 32'hA0), mk(2'b01, 1'b1, 32'hA1),
                mk(2'b01, 1'b1, 32'hA2), mk(2'b10, 1'b1, 32'hA3)};
      check_seq("four", 1'b1, hs + 2);
      check("four_pkt_count", pkt_count_o, 2);

      // Round-robin: 11 -> vc0, 11 -> vc1, 01 -> vc0, 10 -> vc1.
      fq.delete(); fc.delete();
      send_desc(4'd1, 4'd0, 4'd0, h1);
      send_desc(4'd1, 4'd1, 4'd0, h2);
      check("rr_gap", h2 - h1, 3);
      wait_flits("rr_a", 2, 20);
      vc_allocatable_i = 2'b01;
      send_desc(4'd1, 4'd2, 4'd0, hs);
      wait_flits("rr_b", 3, 20);
      vc_allocatable_i = 2'b10;
      send_desc(4'd1, 4'd3, 4'd0, hs);
      wait_flits("rr_c", 4, 20);
      exp_q = '{mk(2'b11, 1'b0, 32'h10), mk(2'b11, 1'b1, 32'h11),
                mk(2'b11, 1'b0, 32'h12), mk(2'b11, 1'b1, 32'h13)};
      check_seq("rr", 1'b0, 0);
      check("rr_pkt_count", pkt_count_o, 6);

      // Backpressure on vc 0 for 3 cycles mid-body; vc 1 stays on and must be ignored.
      vc_allocatable_i = 2'b11;
      fq.delete(); fc.delete();
      for (int i = 0; i < 6; i++) pld_q.push_back(32'hB0 + i);
      send_desc(4'd6, 4'd6, 4'd6, hs);
      wait_flits("bp_pre", 3, 30);
      on_off_i = 2'b10;
      for (int d = 0; d < 3; d++) begin
         if (d > 0) step();
         #1;
         check($sformatf("bp_pld_ready[%0d]", d), pld_ready_o, 0);
         if (d > 0) check($sformatf("bp_valid[%0d]", d), valid_flit_o, 0);
      end
      step();
      on_off_i = 2'b11;
      wait_flits("bp", 7, 40);
      exp_q = '{mk(2'b00, 1'b0, 32'h66), mk(2'b01, 1'b0, 32'hB0), mk(2'b01, 1'b0, 32'hB1),
                mk(2'b01, 1'b0, 32'hB2), mk(2'b01, 1'b0, 32'hB3), mk(2'b01, 1'b0, 32'hB4),
                mk(2'b10, 1'b0, 32'hB5)};
      check_seq("bp", 1'b0, 0);
      if (fc.size() == 7) check("bp_span", fc[6] - fc[0], 9);
      check("bp_pkt_count", pkt_count_o, 7);

      // Allocation stall, then reset in the middle of the body.
      vc_allocatable_i = 2'b00;
      fq.delete(); fc.delete();
      for (int i = 0; i < 4; i++) pld_q.push_back(32'hC0 + i);
      send_desc(4'd4, 4'd4, 4'd4, hs);
      repeat (10) step();
      check("stall_busy", busy_o, 1);
      check("stall_flits", fq.size(), 0);
      check("stall_ready", pkt_ready_o, 0);
      vc_allocatable_i = 2'b01;
      wait_flits("mid", 2, 20);
      check("mid_busy", busy_o, 1);
      rst = 1'b0;
      pld_q.delete();
      #1;
      check("arst_valid", valid_flit_o, 0);
      check("arst_data", data_o, 0);
      check("arst_count", pkt_count_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_ready", pkt_ready_o, 1);
      check("arst_pld_ready", pld_ready_o, 0);
      repeat (2) step();
      rst = 1'b1;
      step();
      fq.delete(); fc.delete();
      vc_allocatable_i = 2'b11;
      pld_q.push_back(32'hD0);
      send_desc(4'd7, 4'd7, 4'd1, hs);
      wait_flits("post", 2, 20);
      exp_q = '{mk(2'b00, 1'b0, 32'h77), mk(2'b10, 1'b0, 32'hD0)};
      check_seq("post", 1'b1, hs + 2);
      check("post_pkt_count", pkt_count_o, 1);

      // Maximum length L=15 -> 16 flits on vc 1.
      fq.delete(); fc.delete();
      for (int i = 0; i < 15; i++) pld_q.push_back(32'hE0 + i);
      send_desc(4'd8, 4'd9, 4'd15, hs);
      wait_flits("max", 16, 60);
      exp_q.delete();
      exp_q.push_back(mk(2'b00, 1'b1, 32'h89));
      for (int i = 0; i < 14; i++) exp_q.push_back(mk(2'b01, 1'b1, 32'hE0 + i));
      exp_q.push_back(mk(2'b10, 1'b1, 32'hEE));
      check_seq("max", 1'b1, hs + 2);
      step();
      check("max_pkt_count", pkt_count_o, 2);
      check("max_extra", fq.size(), 16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
